// File: rtl/pc_unit.sv
// pc_unit: program counter with exception vectoring and a circular
// return-address stack (RAS) used for call/return prediction.
module pc_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1,
  parameter logic [WIDTH-1:0]   INC       = WIDTH'(4),
  parameter logic [WIDTH-1:0]   EXC_VEC   = WIDTH'(32'h0000_0080),
  parameter int                 RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  input  logic             exc,
  output logic [WIDTH-1:0] PC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_JMP = 2'd2;
  localparam logic [1:0] SRC_RET = 2'd3;

  // Architectural state
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    head_q, head_d;   // next free slot; top is head_q-1
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  // Stack storage, not reset
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q;

  // Write port into the stack
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_val;

  // Derived values
  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] top_val;
  logic             empty, full;
  logic             do_ret, do_pop;

  assign pc_inc  = pc_q + INC;          // wraps modulo 2^WIDTH
  assign top_idx = head_q - PW'(1);     // modulo RAS_DEPTH (power of two)
  assign top_val = ras_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign do_ret  = PCWrite && (pc_src == SRC_RET);
  assign do_pop  = do_ret && !empty;

  // Next-state selection: exception beats PCWrite beats hold
  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    wr_en  = 1'b0;
    wr_idx = head_q;
    wr_val = pc_inc;
    if (exc) begin
      // RAS deliberately untouched on an exception
      pc_d = EXC_VEC;
    end else if (PCWrite) begin
      unique case (pc_src)
        SRC_SEQ:         pc_d = pc_inc;
        SRC_BR, SRC_JMP: pc_d = target;
        default: begin
          // Return on an empty stack falls back to target and flags underflow
          if (empty) begin
            pc_d  = target;
            err_d = 1'b1;
          end else begin
            pc_d  = top_val;
          end
        end
      endcase

      if (do_pop && call) begin
        // Return-and-call: swap top entry in place, depth unchanged
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (do_pop) begin
        head_d = top_idx;
        cnt_d  = cnt_q - CW'(1);
      end else if (call) begin
        // Push; when full this lands on the oldest entry (circular)
        wr_en  = 1'b1;
        wr_idx = head_q;
        head_d = head_q + PW'(1);
        if (full) err_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // PC, stack pointer, count and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_VAL;
      head_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Stack entry write; contents survive reset (only count is cleared)
  always_ff @(posedge clk) begin
    if (wr_en && !rst) ras_q[wr_idx] <= wr_val;
  end

  assign PC        = pc_q;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential wrap, call/return,
// overflow/underflow, return+call combinations and exceptions.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCWrite = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] target = 32'd0;
  logic        call = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] PC;
  logic        ras_empty, ras_full, ras_err;

  int nvec = 0;
  int nerr = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .pc_src(pc_src),
    .target(target), .call(call), .exc(exc), .PC(PC),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f, input logic r);
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e});
    chk({tag, ".full"},  {31'd0, ras_full},  {31'd0, f});
    chk({tag, ".err"},   {31'd0, ras_err},   {31'd0, r});
  endtask

  // Apply one request, take one rising edge, settle 1 time unit past it
  task automatic step(input logic pw, input logic [1:0] src, input logic [31:0] tgt,
                      input logic cl, input logic ex);
    PCWrite = pw; pc_src = src; target = tgt; call = cl; exc = ex;
    @(posedge clk); #1;
  endtask

  initial begin
    // Let the clock run a bit, then assert reset between edges (t=12)
    #12 rst = 1'b1;
    #1;
    chk("rst_async.pc", PC, 32'hFFFF_FFFF);
    chk_flags("rst_async", 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential increments wrap from all-ones
    step(1, 0, 0, 0, 0); chk("seq1", PC, 32'd3);
    step(1, 0, 0, 0, 0); chk("seq2", PC, 32'd7);
    step(1, 0, 0, 0, 0); chk("seq3", PC, 32'd11);
    step(0, 0, 32'h55, 1, 0); chk("hold", PC, 32'd11);
    chk_flags("hold", 1'b1, 1'b0, 1'b0);

    // Call then return
    step(1, 1, 32'h100, 0, 0); chk("br", PC, 32'h100);
    step(1, 2, 32'h400, 1, 0); chk("call_jmp", PC, 32'h400);
    chk_flags("call_jmp", 1'b0, 1'b0, 1'b0);
    step(1, 3, 32'hDEAD, 0, 0); chk("ret", PC, 32'h104);
    chk_flags("ret", 1'b1, 1'b0, 1'b0);

    // Five calls into a 4-deep stack: first return address is lost
    step(1, 1, 32'h1000, 1, 0); chk("c1", PC, 32'h1000);
    step(1, 1, 32'h2000, 1, 0); chk("c2", PC, 32'h2000);
    step(1, 1, 32'h3000, 1, 0); chk("c3", PC, 32'h3000);
    step(1, 1, 32'h4000, 1, 0); chk("c4", PC, 32'h4000);
    chk_flags("c4", 1'b0, 1'b1, 1'b0);
    step(1, 1, 32'h5000, 1, 0); chk("c5", PC, 32'h5000);
    chk_flags("c5", 1'b0, 1'b1, 1'b1);
    step(1, 3, 0, 0, 0); chk("r5", PC, 32'h4004);
    chk_flags("r5", 1'b0, 1'b0, 1'b1);
    step(1, 3, 0, 0, 0); chk("r4", PC, 32'h3004);
    step(1, 3, 0, 0, 0); chk("r3", PC, 32'h2004);
    step(1, 3, 0, 0, 0); chk("r2", PC, 32'h1004);
    chk_flags("r2", 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with every request active
    PCWrite = 1; pc_src = 1; target = 32'h1234; call = 1; exc = 1;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.pc", PC, 32'hFFFF_FFFF);
    chk_flags("rst_mid", 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold.pc", PC, 32'hFFFF_FFFF);
    chk_flags("rst_hold", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Underflow: return on empty stack goes to target
    step(1, 3, 32'h200, 0, 0); chk("underflow", PC, 32'h200);
    chk_flags("underflow", 1'b1, 1'b0, 1'b1);

    // Return+call on non-empty stack swaps top
    rst = 1'b1; #1; rst = 1'b0;
    step(1, 1, 32'h300, 0, 0); chk("j300", PC, 32'h300);
    step(1, 2, 32'h500, 1, 0); chk("call500", PC, 32'h500);
    step(1, 3, 32'hBAD, 1, 0); chk("retcall", PC, 32'h304);
    chk_flags("retcall", 1'b0, 1'b0, 1'b0);
    step(1, 3, 32'hBAD, 0, 0); chk("ret_swap", PC, 32'h504);
    chk_flags("ret_swap", 1'b1, 1'b0, 1'b0);

    // Return+call on empty stack: target, push, error
    step(1, 3, 32'h600, 1, 0); chk("retcall_empty", PC, 32'h600);
    chk_flags("retcall_empty", 1'b0, 1'b0, 1'b1);
    step(1, 3, 32'hBAD, 0, 0); chk("ret_after", PC, 32'h508);
    chk_flags("ret_after", 1'b1, 1'b0, 1'b1);

    // Exception overrides everything and leaves the RAS alone
    step(1, 1, 32'h700, 1, 0); chk("call700", PC, 32'h700);
    step(1, 1, 32'h999, 1, 1); chk("exc", PC, 32'h80);
    chk_flags("exc", 1'b0, 1'b0, 1'b1);
    step(1, 3, 32'hBAD, 0, 0); chk("ret_exc", PC, 32'h50C);
    chk_flags("ret_exc", 1'b1, 1'b0, 1'b1);
    step(0, 3, 32'hBAD, 1, 0); chk("hold2", PC, 32'h50C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter RESET_VAL, default all-ones (32'hFFFFFFFF): PC value loaded by reset.
REQ-003 Parameter INC, default 4: sequential increment step.
REQ-004 Parameter EXC_VEC, default 32'h00000080: exception vector address.
REQ-005 Parameter RAS_DEPTH, default 4, power of two, minimum 2: return-address-stack entries.
REQ-006 The clock and reset ports SHALL be as follows.
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, asynchronous, active-high.
REQ-007 The remaining ports SHALL be as follows.
- PCWrite  in  1: enables a PC update this cycle.
- pc_src  in  2: 0 = PC+INC, 1 = branch target, 2 = jump target, 3 = return (RAS pop).
- target  in  WIDTH: branch or jump address.
- call  in  1: push the return address; honoured only with PCWrite=1.
- exc  in  1: exception request.
- PC  out  WIDTH: current PC, registered.
- ras_empty  out  1: RAS holds 0 entries.
- ras_full  out  1: RAS holds RAS_DEPTH entries.
- ras_err  out  1: sticky flag for underflow or overflow.

Function
REQ-008 Priority each cycle SHALL be: exc, then PCWrite, then hold.
REQ-009 exc=1 SHALL load PC <= EXC_VEC regardless of PCWrite, pc_src and call; the RAS is unchanged.
REQ-010 With exc=0 and PCWrite=1, the next PC SHALL be selected by pc_src:
- 0: PC+INC.
- 1 or 2: target.
- 3: top of RAS.
REQ-011 PC+INC SHALL be computed modulo 2^WIDTH, so RESET_VAL+4 wraps to 3 at WIDTH=32.
REQ-012 With exc=0 and PCWrite=0, PC, the RAS and all flags SHALL hold.
REQ-013 call=1 with PCWrite=1 and exc=0 SHALL push the old PC+INC, not the new PC.
REQ-014 A push when full SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH and set ras_err.
REQ-015 pc_src=3 with an empty RAS SHALL load PC <= target, leave count at 0 and set ras_err.
REQ-016 pc_src=3 with call=1 in the same cycle SHALL load PC <= old top and replace the top with PC+INC; count is unchanged and there is no overflow.
REQ-017 pc_src=3 with an empty RAS and call=1 SHALL load PC <= target, push PC+INC (count becomes 1) and set ras_err.
REQ-018 Stack pointer arithmetic SHALL be modulo RAS_DEPTH; count SHALL range 0..RAS_DEPTH.
REQ-019 ras_empty and ras_full SHALL be combinational decodes of the registered count, valid the cycle after the update.
REQ-020 ras_err SHALL remain set until reset.
REQ-021 Latency: PC and the flags SHALL reflect a request one clock edge after it is sampled; there are no combinational paths from inputs to PC.

Reset
REQ-022 While rst=1, asynchronously and independent of clk: PC = RESET_VAL, count = 0, ras_empty = 1, ras_full = 0, ras_err = 0.
REQ-023 RAS entry contents need not be cleared.
REQ-024 Reset asserted mid-operation SHALL override exc, PCWrite and call.
REQ-025 After rst falls, the first update SHALL occur on the next rising clk edge.

Verification
REQ-026 Assert rst between clock edges -> PC=32'hFFFFFFFF immediately; ras_empty=1; ras_err=0.
REQ-027 After reset, PCWrite=1, pc_src=0 for 3 cycles -> PC sequence 3, 7, 11 (wrap check); PCWrite=0 -> PC holds 11.
REQ-028 PC=0x100: call with pc_src=2, target=0x400 -> PC=0x400, count 1. Then pc_src=3 -> PC=0x104, ras_empty=1.
REQ-029 Five calls with RAS_DEPTH=4 -> ras_full=1, ras_err=1. Then four returns yield pushed addresses 5, 4, 3, 2 in order; the first is lost. Then ras_empty=1.
REQ-030 Empty RAS, pc_src=3, target=0x200 -> PC=0x200, ras_err=1, count 0.
REQ-031 exc=1 with PCWrite=1, pc_src=1, call=1 -> PC=0x80, RAS count unchanged.
